prng_arbiter: RTL and testbench
===============================

# prng_arbiter

Shares one `lfsr_prng` output stream among several IFU consumers, such as I-cache and BTB random-replacement way pickers. Each consumer gets exactly one random value per request, and no value is handed to two consumers. After reset the block discards a configurable number of warm-up cycles. It reduces the raw value to the range [0, LIMIT) by rejection sampling, with a bounded retry count, and grants requesters in round-robin order. It sits between `lfsr_prng.output_number_o` and the requesting units, and does not instantiate the PRNG itself.

## Interface
- `NREQ`, default 4: number of requesters (2..8).
- `RW`, default 3: random value width; must equal the `SIZE` of the feeding `lfsr_prng`.
- `LIMIT`, default 6: exclusive upper bound on returned values, 1..2**RW.
- `MAXTRY`, default 4: consecutive rejections (1..15) before the fallback value is issued.
- `WARMUP`, default 16: cycles discarded after reset (1..255).
- `clk`, input, 1: clock.
- `rst_l`, input, 1: reset, asynchronous, active-low.
- `rnd_i`, input, RW: raw random value, one new value per cycle.
- `req_i`, input, NREQ: single-cycle request pulses, one bit per requester.
- `gnt_o`, output, NREQ: registered grant, one-hot or zero.
- `rnd_o`, output, RW: registered value; valid only in a cycle where `gnt_o` != 0.
- `ready_o`, output, 1: warm-up complete, registered.

## Operation
- **State:**
  - `pend[NREQ]`
  - `rr_ptr` (log2 NREQ bits)
  - `try_cnt` (4 bits)
  - `wu_cnt` (8 bits)
  - FSM {WARMUP, RUN}
- **Reset:** all state cleared; FSM=WARMUP; `gnt_o`=0, `rnd_o`=0, `ready_o`=0.
- **Request capture:**
  - `eff = pend | req_i`.
  - `pend[i]` is set by `req_i[i]` and cleared when requester i is granted.
  - If a new `req_i[i]` arrives in the cycle i is granted, `pend[i]` stays 1 (set wins).
  - A pulse on a bit that is already pending is merged: one grant only.
- **WARMUP:**
  - `wu_cnt` increments every cycle; no grants are issued; requests accumulate in `pend`.
  - When `wu_cnt` == WARMUP-1, the FSM moves to RUN and `ready_o` rises on the next edge.
- **RUN, arbitration:**
  - Among `eff`, the winner is the first set bit at or after `rr_ptr`, wrapping modulo NREQ.
  - If `eff` == 0: no action, and `try_cnt` holds its value.
- **RUN, acceptance (when `eff` != 0):**
  - If `rnd_i` < LIMIT: grant the winner with `rnd_o = rnd_i`; `try_cnt` := 0.
  - Else if `try_cnt` == MAXTRY-1: grant the winner with `rnd_o = LIMIT-1` (fallback); `try_cnt` := 0.
  - Else: no grant; `try_cnt` += 1.
- **After any grant to i:** `rr_ptr` := (i+1) mod NREQ.
- **LIMIT == 2**RW:** every value is accepted; `try_cnt` stays 0.
- **Requester side:**
  - A requester must not rely on `rnd_o` outside its own `gnt_o` cycle.
  - A requester may pulse a new request in its grant cycle.
- **Grant rate:** at most one grant per cycle.
- **RUN is terminal** until the next reset.

## Timing
- A request pulse in cycle t, in RUN, winning arbitration and accepted, produces `gnt_o` / `rnd_o` in cycle t+1. Minimum latency is 1 cycle.
- `rnd_o` equals the `rnd_i` sampled in the arbitration cycle, not the value present during the grant cycle.
- **Worst-case latency** for a requester with NREQ-1 competitors is NREQ·MAXTRY cycles after RUN is entered.
- **`ready_o`:** 0 for cycles 0..WARMUP-1 after reset release, 1 from cycle WARMUP.
- **First grant:** requests pending at the end of warm-up can be granted at the earliest in cycle WARMUP+1.
- **`gnt_o`** is a one-cycle pulse per grant.
- **`rst_l` asserted mid-operation:**
  - All outputs clear immediately (asynchronous reset).
  - Pending requests are dropped; the requester must re-issue them.
  - Warm-up restarts after reset release.

## Test plan
Parameters for all scenarios: NREQ=4, RW=3, LIMIT=6, MAXTRY=4, WARMUP=16.
- **Reset and warm-up:** release reset, `rnd_i`=1, no req. Required: `gnt_o`=0 and `rnd_o`=0 throughout; `ready_o`=0 for cycles 0..15 and 1 from cycle 16.
- **Single request:** in RUN, `req_i`=0001 pulse with `rnd_i`=2. Required: next cycle `gnt_o`=0001, `rnd_o`=2, `pend` empty.
- **Round-robin:** in RUN with `rr_ptr`=0, `req_i`=1111 pulse, `rnd_i`=1 held. Required: `gnt_o` = 0001, 0010, 0100, 1000 on four consecutive cycles, then 0.
- **Rejection:**
  - `req_i`=0100 with `rnd_i`=7 held. Required: no grant for 3 cycles, then `gnt_o`=0100, `rnd_o`=5 (fallback).
  - Repeat with `rnd_i`=6, 6, 3. Required: grant on the third cycle with `rnd_o`=3.
- **Warm-up queuing and merge:** `req_i`=0010 pulsed twice during warm-up. Required: exactly one `gnt_o`=0010 at cycle 17, and none before `ready_o`.
- **Mid-operation reset:** with `pend`=1011 and 7s on `rnd_i`, assert `rst_l`=0. Required: `gnt_o`=0 and `ready_o`=0 immediately; after release, no grants without new requests.

Source files
------------

// File: rtl/prng_arbiter.sv
// Shares one lfsr_prng output stream among NREQ consumers: warm-up discard,
// rejection sampling into [0, LIMIT) with bounded retries, round-robin grants.
module prng_arbiter #(
  parameter int NREQ   = 4,
  parameter int RW     = 3,
  parameter int LIMIT  = 6,
  parameter int MAXTRY = 4,
  parameter int WARMUP = 16
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic [RW-1:0]   rnd_i,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [RW-1:0]   rnd_o,
  output logic            ready_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [RW:0]   LIMIT_W  = (RW+1)'(LIMIT);
  localparam logic [RW-1:0] FALLBACK = RW'(LIMIT - 1);
  localparam logic [3:0]    TRY_LAST = 4'(MAXTRY - 1);
  localparam logic [7:0]    WU_LAST  = 8'(WARMUP - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(NREQ - 1);

  typedef enum logic {
    ST_WARMUP,
    ST_RUN
  } state_t;

  state_t          state;
  logic [NREQ-1:0] pend;
  logic [PW-1:0]   rr_ptr;
  logic [3:0]      try_cnt;
  logic [7:0]      wu_cnt;

  logic [NREQ-1:0] eff;
  logic [NREQ-1:0] gnt_vec;
  logic            win_valid;
  logic [PW-1:0]   win_idx;
  logic            accept;
  logic            fallback;
  logic            do_grant;
  logic [RW-1:0]   gnt_val;

  // First set bit of e at or after ptr, wrapping; MSB of result flags a hit.
  function automatic logic [PW:0] find_winner(input logic [NREQ-1:0] e,
                                              input logic [PW-1:0]   ptr);
    logic          found;
    logic [PW-1:0] best;
    logic [PW-1:0] idx_l;
    int            idx;
    found = 1'b0;
    best  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_l = PW'(idx);
      if (!found && e[idx_l]) begin
        found = 1'b1;
        best  = idx_l;
      end
    end
    return {found, best};
  endfunction

  assign eff                  = pend | req_i;
  assign {win_valid, win_idx} = find_winner(eff, rr_ptr);
  assign accept               = ({1'b0, rnd_i} < LIMIT_W);
  assign fallback             = !accept && (try_cnt == TRY_LAST);
  assign do_grant             = (state == ST_RUN) && win_valid && (accept || fallback);
  assign gnt_vec              = do_grant ? (NREQ'(1) << win_idx) : '0;
  assign gnt_val              = accept ? rnd_i : FALLBACK;

  // A request pulsed while already pending folds into the same pend bit;
  // the winner's bit is consumed by the grant it receives.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state   <= ST_WARMUP;
      pend    <= '0;
      rr_ptr  <= '0;
      try_cnt <= '0;
      wu_cnt  <= '0;
      gnt_o   <= '0;
      rnd_o   <= '0;
      ready_o <= 1'b0;
    end else begin
      pend  <= eff & ~gnt_vec;
      gnt_o <= gnt_vec;
      case (state)
        ST_WARMUP: begin
          wu_cnt <= wu_cnt + 8'd1;
          if (wu_cnt == WU_LAST) begin
            state   <= ST_RUN;
            ready_o <= 1'b1;
          end
        end
        ST_RUN: begin
          if (win_valid) begin
            if (do_grant) begin
              rnd_o   <= gnt_val;
              try_cnt <= '0;
              rr_ptr  <= (win_idx == PTR_LAST) ? '0 : win_idx + PW'(1);
            end else begin
              try_cnt <= try_cnt + 4'd1;
            end
          end
        end
        default: state <= ST_WARMUP;
      endcase
    end
  end

endmodule

// File: tb/tb_prng_arbiter.sv
// Self-checking bench for prng_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against a request-list reference model.
module tb_prng_arbiter;

  localparam int NREQ   = 4;
  localparam int RW     = 3;
  localparam int LIMIT  = 6;
  localparam int MAXTRY = 4;
  localparam int WARMUP = 16;

  logic            clk = 1'b0;
  logic            rst_l = 1'b0;
  logic [RW-1:0]   rnd_i = '0;
  logic [NREQ-1:0] req_i = '0;
  logic [NREQ-1:0] gnt_o;
  logic [RW-1:0]   rnd_o;
  logic            ready_o;

  prng_arbiter #(
    .NREQ(NREQ), .RW(RW), .LIMIT(LIMIT), .MAXTRY(MAXTRY), .WARMUP(WARMUP)
  ) dut (
    .clk(clk), .rst_l(rst_l), .rnd_i(rnd_i), .req_i(req_i),
    .gnt_o(gnt_o), .rnd_o(rnd_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: waiting requesters, next-in-line pointer, rejection run
  // length and elapsed cycles since reset release.
  bit              m_wait[NREQ];
  int              m_next;
  int              m_rejects;
  int              m_cycle;
  bit              m_granted;
  logic [NREQ-1:0] exp_gnt;
  logic [RW-1:0]   exp_rnd;
  logic            exp_ready;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NREQ; i++) m_wait[i] = 1'b0;
    m_next    = 0;
    m_rejects = 0;
    m_cycle   = 0;
    m_granted = 1'b0;
    exp_gnt   = '0;
    exp_rnd   = '0;
    exp_ready = 1'b0;
  endtask

  task automatic modelStep(input logic [NREQ-1:0] req, input logic [RW-1:0] rnd);
    int w;
    int v;
    exp_gnt = '0;
    v = -1;
    for (int i = 0; i < NREQ; i++) if (req[i]) m_wait[i] = 1'b1;
    if (m_cycle >= WARMUP) begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_next + k) % NREQ;
        if (w < 0 && m_wait[j]) w = j;
      end
      if (w >= 0) begin
        if (int'(rnd) < LIMIT) v = int'(rnd);
        else if (m_rejects == MAXTRY - 1) v = LIMIT - 1;
        else m_rejects++;
        if (v >= 0) begin
          exp_gnt[w] = 1'b1;
          exp_rnd    = RW'(v);
          m_wait[w]  = 1'b0;
          m_next     = (w + 1) % NREQ;
          m_rejects  = 0;
          m_granted  = 1'b1;
        end
      end
    end
    m_cycle++;
    exp_ready = (m_cycle >= WARMUP);
  endtask

  task automatic checkCycle();
    checkOutput("gnt", 32'(gnt_o), 32'(exp_gnt));
    checkOutput("ready", 32'(ready_o), 32'(exp_ready));
    if (exp_gnt != '0) checkOutput("rnd", 32'(rnd_o), 32'(exp_rnd));
    else if (!m_granted) checkOutput("rnd_idle", 32'(rnd_o), 32'd0);
  endtask

  // Drive one cycle of inputs, advance to the following negedge, check.
  task automatic applyStimulus(input logic [NREQ-1:0] req, input logic [RW-1:0] rnd);
    req_i = req;
    rnd_i = rnd;
    modelStep(req, rnd);
    @(posedge clk);
    @(negedge clk);
    req_i = '0;
    checkCycle();
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_l = 1'b0;
    req_i = '0;
    #1;
    checkOutput("rst_gnt", 32'(gnt_o), 32'd0);
    checkOutput("rst_ready", 32'(ready_o), 32'd0);
    checkOutput("rst_rnd", 32'(rnd_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    modelReset();
    checkCycle();
  endtask

  initial begin
    logic [NREQ-1:0] rr_exp [5];
    int gcount;
    int gcycle;

    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0000;

    // Reset and warm-up: ready rises exactly at cycle WARMUP.
    resetDut();
    for (int c = 1; c <= WARMUP + 1; c++) begin
      applyStimulus('0, 3'd1);
      checkOutput("wu_ready", 32'(ready_o), (c >= WARMUP) ? 32'd1 : 32'd0);
    end

    // Single request with an in-range value.
    applyStimulus(4'b0001, 3'd2);
    checkOutput("single_gnt", 32'(gnt_o), 32'h1);
    checkOutput("single_rnd", 32'(rnd_o), 32'd2);
    applyStimulus('0, 3'd7);
    checkOutput("single_once", 32'(gnt_o), 32'h0);

    // Bring the pointer back to 0, then all four request at once.
    applyStimulus(4'b1000, 3'd1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus((k == 0) ? 4'b1111 : 4'b0000, 3'd1);
      checkOutput("rr_gnt", 32'(gnt_o), 32'(rr_exp[k]));
    end

    // Rejection until fallback, then acceptance after two rejects.
    applyStimulus(4'b0100, 3'd7);
    applyStimulus('0, 3'd7);
    applyStimulus('0, 3'd7);
    checkOutput("rej_wait", 32'(gnt_o), 32'h0);
    applyStimulus('0, 3'd7);
    checkOutput("fb_gnt", 32'(gnt_o), 32'h4);
    checkOutput("fb_rnd", 32'(rnd_o), 32'(LIMIT - 1));
    applyStimulus(4'b0100, 3'd6);
    applyStimulus('0, 3'd6);
    applyStimulus('0, 3'd3);
    checkOutput("acc_gnt", 32'(gnt_o), 32'h4);
    checkOutput("acc_rnd", 32'(rnd_o), 32'd3);

    // Two pulses from one requester during warm-up yield a single grant.
    resetDut();
    gcount = 0;
    gcycle = -1;
    for (int c = 0; c < WARMUP + 6; c++) begin
      applyStimulus((c == 3 || c == 7) ? 4'b0010 : 4'b0000, 3'($urandom_range(0, LIMIT - 1)));
      if (gnt_o != '0) begin
        gcount++;
        if (gcycle < 0) gcycle = c + 1;
      end
    end
    checkOutput("merge_count", 32'(gcount), 32'd1);
    checkOutput("merge_cycle", 32'(gcycle), 32'(WARMUP + 1));

    // Random traffic against the model.
    for (int c = 0; c < 400; c++)
      applyStimulus(NREQ'($urandom & $urandom), 3'($urandom_range(0, 7)));

    // Mid-operation reset drops pending requests.
    applyStimulus(4'b1011, 3'd7);
    applyStimulus('0, 3'd7);
    resetDut();
    gcount = 0;
    for (int c = 0; c < WARMUP + 8; c++) begin
      applyStimulus('0, 3'($urandom_range(0, 7)));
      if (gnt_o != '0) gcount++;
    end
    checkOutput("post_rst_grants", 32'(gcount), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
